cnt_seq: RTL
============

// Module: cnt_seq
// PURPOSE
//  Command sequencer directly upstream of the 8-bit up/down counter; turns queued
//  commands (load, clear, step up/down N) into the counter's Reset/Enable/Load/UpDn/Data
//  controls. Reads back counter Q. Accepts one command at a time over valid/ready; Done pulses on completion.
// PARAMETERS
//  W        8   counter data / step-count width
// PORTS
//  Clock      in   1  single clock, all logic posedge
//  Reset_n    in   1  asynchronous, active-low reset
//  CmdValid   in   1  command present
//  CmdReady   out  1  sequencer can accept (high only in IDLE)
//  CmdOp      in   2  0=CLEAR 1=LOAD 2=UP 3=DOWN
//  CmdArg     in   W  LOAD: value; UP/DOWN: step count N; CLEAR: ignored
//  Abort      in   1  terminate an in-progress UP/DOWN
//  Busy       out  1  command in progress (!CmdReady)
//  Done       out  1  one-cycle completion pulse
//  Sat        out  1  valid with Done; command ended at a boundary (macro only, else 0)
//  CntReset   out  1  to counter, active-high
//  CntEnable  out  1  to counter
//  CntLoad    out  1  to counter
//  CntUpDn    out  1  to counter, 1=up
//  CntData    out  W  to counter
//  CntQ       in   W  counter output
// BEHAVIOUR
//  Reset (Reset_n=0, any time, incl. mid-command): state IDLE, CntReset=1, all other outputs 0,
//   Remaining=0. CntReset drops at first Clock edge after release. Reset is the only asynchronous path.
//  FSM states: IDLE, CLR, LOAD, STEP.
//  IDLE: CmdReady=1. Accept on CmdValid&CmdReady at edge k:
//   CLEAR -> CLR; LOAD -> LOAD (CntData<=CmdArg); UP/DOWN, N>0 -> STEP (Remaining<=N,
//   CntUpDn<=op==UP); UP/DOWN, N=0 -> stay IDLE, Done=1 next cycle, no counter activity.
//  CLR: CntReset=1 for exactly one cycle -> IDLE, Done=1.
//  LOAD: CntEnable=1, CntLoad=1, CntData=arg for exactly one cycle -> IDLE, Done=1.
//  STEP: CntEnable=1, CntLoad=0 each cycle; Remaining decrements per cycle; after the
//   cycle with Remaining==1 -> IDLE, Done=1. UP/DOWN N issues exactly N enabled cycles.
//  Done is asserted in the first IDLE cycle after a command, coincident with CmdReady=1; CntQ
//   already holds the result then. Back-to-back: a command accepted in the Done cycle is legal.
//  All counter-control outputs are registered, except CntEnable gating under the macro.
//  CntData holds last value when not loading. Arithmetic: Remaining is W-bit unsigned, no wrap.
//  Abort: sampled only in STEP; the current cycle's step still completes; no further enabled
//   cycles; -> IDLE, Done=1. Abort on the cycle with Remaining==1 is indistinguishable from
//   normal completion. Abort in IDLE/CLR/LOAD ignored.
//  Without the macro, the counter wraps naturally (0xFF+1=0x00, 0x00-1=0xFF).
// CONFIGURATION
//  CNT_SEQ_SATURATE_EN defined: in STEP, CntEnable = state==STEP && !(UpDn ? CntQ=='1 : CntQ==0),
//   combinational. On the first cycle the boundary check suppresses a step, the command ends:
//   -> IDLE, Done=1, Sat=1. Remaining steps are discarded. Q never wraps.
//  Not defined: CntEnable purely registered, Sat tied 0, wrap as above.
// STRUCTURE
//  Package cnt_seq_pkg: cmd_op_e (CLEAR/LOAD/UP/DOWN), seq_state_e, W default constant.
//  Sub-module cnt_seq_steps: W-bit remaining-step down-counter with load, dec, and last-step
//   (==1) flag.
// TESTING (bench instantiates cnt_seq + counter, checks Q and pins)
//  1. Reset_n=0 mid-STEP -> immediately CntReset=1, Busy=0, CntEnable=0; Q=0x00.
//  2. LOAD 0x5A -> one cycle CntEnable=CntLoad=1, CntData=0x5A; Done next cycle, Q=0x5A.
//  3. LOAD 0x10, UP 5 -> exactly 5 enabled cycles, Done with Q=0x15; DOWN 0 -> Done, Q unchanged.
//  4. LOAD 0xFD, UP 5 -> no macro: Q=0x02, Sat=0; macro: Q=0xFF, Sat=1 after 2 steps.
//  5. LOAD 0x40, DOWN 10, Abort in 3rd STEP cycle -> Q=0x3D, Done=1, then CmdReady=1.
//  6. CLEAR from Q=0x77, then a command held valid in the Done cycle -> Q=0x00, next accepted, no gap.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
package cnt_seq_pkg;

   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      OP_CLEAR = 2'd0,
      OP_LOAD  = 2'd1,
      OP_UP    = 2'd2,
      OP_DOWN  = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_LOAD = 2'd2,
      S_STEP = 2'd3
   } seq_state_e;

endpackage

// File: rtl/cnt_seq_steps.sv
// Remaining-step down-counter for UP/DOWN commands; flags the final step.
module cnt_seq_steps
   import cnt_seq_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         load,
   input  logic         dec,
   input  logic         clr,
   input  logic [W-1:0] load_val,
   output logic         last
);

   logic [W-1:0] remaining;

   // Load N on accept, count down once per step, clear when a command is cut short.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         remaining <= '0;
      end else if (clr) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= load_val;
      end else if (dec && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign last = (remaining == W'(1));

endmodule

// File: rtl/cnt_seq.sv
// Command sequencer driving an up/down counter's Reset/Enable/Load/UpDn/Data.
// Optional build macro: CNT_SEQ_SATURATE_EN (stop stepping at 0x00 / all-ones, report Sat).
module cnt_seq
   import cnt_seq_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         CmdValid,
   output logic         CmdReady,
   input  logic [1:0]   CmdOp,
   input  logic [W-1:0] CmdArg,
   input  logic         Abort,
   output logic         Busy,
   output logic         Done,
   output logic         Sat,
   output logic         CntReset,
   output logic         CntEnable,
   output logic         CntLoad,
   output logic         CntUpDn,
   output logic [W-1:0] CntData,
   input  logic [W-1:0] CntQ
);

   seq_state_e   state, state_nxt;
   cmd_op_e      op;
   logic         last;
   logic         rem_load, rem_dec, rem_clr;

   logic         cnt_reset_r, cnt_reset_nxt;
   logic         cnt_enable_r, cnt_enable_nxt;
   logic         cnt_load_r, cnt_load_nxt;
   logic         cnt_updn_r, cnt_updn_nxt;
   logic [W-1:0] cnt_data_r, cnt_data_nxt;
   logic         done_r, done_nxt;
   logic         sat_r, sat_nxt;
   logic         bound;

   assign op = cmd_op_e'(CmdOp);

`ifdef CNT_SEQ_SATURATE_EN
   function automatic logic at_bound(input logic up, input logic [W-1:0] q);
      return up ? (q == '1) : (q == '0);
   endfunction

   assign bound = at_bound(cnt_updn_r, CntQ);
`else
   logic unused_q;
   assign unused_q = ^CntQ;
   assign bound    = 1'b0;
`endif

   cnt_seq_steps #(.W(W)) u_steps (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .load     (rem_load),
      .dec      (rem_dec),
      .clr      (rem_clr),
      .load_val (CmdArg),
      .last     (last)
   );

   // State register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next state plus next value of every registered counter-control output.
   always_comb begin
      state_nxt      = state;
      cnt_reset_nxt  = 1'b0;
      cnt_enable_nxt = 1'b0;
      cnt_load_nxt   = 1'b0;
      cnt_updn_nxt   = cnt_updn_r;
      cnt_data_nxt   = cnt_data_r;
      done_nxt       = 1'b0;
      sat_nxt        = 1'b0;
      rem_load       = 1'b0;
      rem_dec        = 1'b0;
      rem_clr        = 1'b0;
      case (state)
         S_IDLE: begin
            if (CmdValid) begin
               case (op)
                  OP_CLEAR: begin
                     state_nxt     = S_CLR;
                     cnt_reset_nxt = 1'b1;
                  end
                  OP_LOAD: begin
                     state_nxt      = S_LOAD;
                     cnt_enable_nxt = 1'b1;
                     cnt_load_nxt   = 1'b1;
                     cnt_data_nxt   = CmdArg;
                  end
                  default: begin
                     // A zero-length step completes at once without touching the counter.
                     if (CmdArg != '0) begin
                        state_nxt      = S_STEP;
                        rem_load       = 1'b1;
                        cnt_updn_nxt   = (op == OP_UP);
                        cnt_enable_nxt = 1'b1;
                     end else begin
                        done_nxt = 1'b1;
                     end
                  end
               endcase
            end
         end
         S_CLR, S_LOAD: begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
         end
         S_STEP: begin
            if (bound) begin
               // Counter sits at its limit: this cycle's step is suppressed and the rest dropped.
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
               sat_nxt   = 1'b1;
               rem_clr   = 1'b1;
            end else begin
               rem_dec = 1'b1;
               if (last || Abort) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
                  rem_clr   = Abort;
               end else begin
                  cnt_enable_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered counter controls; reset holds the counter in reset.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_reset_r  <= 1'b1;
         cnt_enable_r <= 1'b0;
         cnt_load_r   <= 1'b0;
         cnt_updn_r   <= 1'b0;
         cnt_data_r   <= '0;
         done_r       <= 1'b0;
         sat_r        <= 1'b0;
      end else begin
         cnt_reset_r  <= cnt_reset_nxt;
         cnt_enable_r <= cnt_enable_nxt;
         cnt_load_r   <= cnt_load_nxt;
         cnt_updn_r   <= cnt_updn_nxt;
         cnt_data_r   <= cnt_data_nxt;
         done_r       <= done_nxt;
         sat_r        <= sat_nxt;
      end
   end

   assign CmdReady = (state == S_IDLE);
   assign Busy     = !CmdReady;
   assign Done     = done_r;
   assign CntReset = cnt_reset_r;
   assign CntLoad  = cnt_load_r;
   assign CntUpDn  = cnt_updn_r;
   assign CntData  = cnt_data_r;

`ifdef CNT_SEQ_SATURATE_EN
   assign CntEnable = (state == S_STEP) ? !bound : cnt_enable_r;
   assign Sat       = sat_r;
`else
   logic unused_sat;
   assign unused_sat = sat_r ^ bound;
   assign CntEnable  = cnt_enable_r;
   assign Sat        = 1'b0;
`endif

endmodule
